// File: rtl/sa_pkg.sv
// sa_pkg: shared sizes, element/matrix types and drain FSM states for the systolic-array drain stage
package sa_pkg;
  localparam int SIZE = 4;
  localparam int I_WIDTH = 16;
  localparam int O_WIDTH = I_WIDTH * SIZE - SIZE;
  localparam int IDX_W = $clog2(SIZE);
  typedef logic [O_WIDTH-1:0] res_t;
  typedef res_t res_mat_t [SIZE][SIZE];
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} st_e;
endpackage

// File: rtl/sa_mat_buf.sv
// sa_mat_buf: one SIZE x SIZE result register bank with whole-matrix write and row/col read mux
module sa_mat_buf
  import sa_pkg::*;
(
  input  logic             clk,
  input  logic             i_we,
  input  res_mat_t         i_mat,
  input  logic [IDX_W-1:0] i_row,
  input  logic [IDX_W-1:0] i_col,
  output res_t             o_dat
);
  res_mat_t r_mem;
  always_ff @(posedge clk)
    if (i_we) r_mem <= i_mat;
  assign o_dat = r_mem[i_row][i_col];
endmodule

// File: rtl/sa_drain.sv
// sa_drain: ping-pong captures result matrices and streams them row-major over valid/ready
module sa_drain
  import sa_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_matrix_vld,
  input  res_mat_t         i_matrix,
  output logic             o_dat_vld,
  input  logic             i_dat_rdy,
  output res_t             o_dat,
  output logic [IDX_W-1:0] o_row,
  output logic [IDX_W-1:0] o_col,
  output logic             o_last,
  output logic             o_ovf,
  input  logic             i_ovf_clr
);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(SIZE - 1);
  st_e              r_st, w_st_nxt;
  logic             r_wr_sel, r_rd_sel, r_ovf;
  logic [IDX_W-1:0] r_row, r_col;
  logic             w_hs, w_rel, w_acc;
  res_t             w_buf0, w_buf1;
  assign o_dat_vld = (r_st != ST_EMPTY);
  assign o_last    = o_dat_vld & (r_row == IDX_MAX) & (r_col == IDX_MAX);
  assign w_hs      = o_dat_vld & i_dat_rdy;
  assign w_rel     = w_hs & o_last;
  // a FULL buffer pair may still accept when the drained matrix is released this cycle
  assign w_acc     = i_matrix_vld & ((r_st != ST_FULL) | w_rel);
  assign o_dat     = o_dat_vld ? (r_rd_sel ? w_buf1 : w_buf0) : '0;
  assign o_row     = r_row;
  assign o_col     = r_col;
  assign o_ovf     = r_ovf;
  sa_mat_buf u_buf0 (
    .clk   (clk),
    .i_we  (w_acc & ~r_wr_sel),
    .i_mat (i_matrix),
    .i_row (r_row),
    .i_col (r_col),
    .o_dat (w_buf0)
  );
  sa_mat_buf u_buf1 (
    .clk   (clk),
    .i_we  (w_acc & r_wr_sel),
    .i_mat (i_matrix),
    .i_row (r_row),
    .i_col (r_col),
    .o_dat (w_buf1)
  );
  always_comb begin
    w_st_nxt = (w_acc & ~w_rel) ? ((r_st == ST_EMPTY) ? ST_ONE : ST_FULL) :
               (~w_acc & w_rel) ? ((r_st == ST_FULL) ? ST_ONE : ST_EMPTY) : r_st;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st     <= ST_EMPTY;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_row    <= '0;
      r_col    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_st     <= w_st_nxt;
      r_wr_sel <= r_wr_sel ^ w_acc;
      r_rd_sel <= r_rd_sel ^ w_rel;
      r_ovf    <= (i_matrix_vld & ~w_acc) | (r_ovf & ~i_ovf_clr);
      if (w_hs) begin
        r_col <= r_col + 1'b1;
        if (r_col == IDX_MAX) r_row <= r_row + 1'b1;
      end
    end
  end
endmodule

// File: doc/sa_drain.md
Name: sa_drain

Overview:
- Downstream stage of the systolic-array core.
- Captures each SIZE x SIZE result matrix from a single-cycle `matrix valid` pulse and holds it in a two-entry ping-pong buffer.
- Serialises every matrix row-major as a valid/ready element stream toward the writeback/AXI-stream side.
- Decouples the array's burst output from a backpressured consumer; overflow is flagged, never silent.

Parameters:
- SIZE, 4, matrix dimension; must be a power of two, >= 2.
- O_WIDTH, 60, result element width; equals the array's output width (I_WIDTH*SIZE-SIZE with I_WIDTH=16).
- IDX_W, $clog2(SIZE), row/column index width; derived, not overridable.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- i_matrix_vld  in  1  single-cycle pulse: i_matrix holds a complete result.
- i_matrix  in  SIZE x SIZE x O_WIDTH  unpacked [row][col] result matrix.
- o_dat_vld  out  1  stream element valid.
- i_dat_rdy  in  1  consumer ready.
- o_dat  out  O_WIDTH  element buf[rd_sel][o_row][o_col]; 0 when o_dat_vld=0.
- o_row  out  IDX_W  row index of the current element.
- o_col  out  IDX_W  column index of the current element.
- o_last  out  1  high with the final element of a matrix (row=col=SIZE-1).
- o_ovf  out  1  sticky: a matrix was dropped because both buffers were full.
- i_ovf_clr  in  1  clears o_ovf.

Behaviour:
- State
  - cnt in {0,1,2} counts full buffers; this is the FSM: EMPTY / ONE / FULL.
  - wr_sel and rd_sel are 1-bit buffer pointers.
  - row_ff and col_ff form the read cursor.
- Reset (rst=1 at posedge)
  - cnt, wr_sel, rd_sel, row_ff, col_ff and o_ovf go to 0.
  - Consequently o_dat_vld=0, o_last=0, o_dat=0, o_row=0, o_col=0.
  - Buffer contents are not reset.
  - Reset mid-stream abandons the current and pending matrices; no partial output afterwards.
- Handshake and outputs
  - hs = o_dat_vld & i_dat_rdy.
  - o_dat_vld = (cnt != 0).
  - o_dat_vld, once high, stays high until hs; o_dat, o_row and o_col are stable while vld & !rdy.
- Read cursor
  - On hs: col_ff increments.
  - When col_ff=SIZE-1: col_ff wraps to 0 and row_ff increments.
  - On hs with o_last: row_ff and col_ff go to 0, rd_sel toggles, and the buffer is released.
- Capture
  - acc = i_matrix_vld & (cnt<2 | (hs & o_last)).
  - On acc: the whole matrix is written to buf[wr_sel] at the posedge and wr_sel toggles.
  - Capture while FULL with a same-cycle release is legal. It overwrites the buffer being drained; its last element was already presented this cycle.
- cnt update
  - cnt_next = cnt + acc - (hs & o_last).
  - Simultaneous accept and release leaves cnt unchanged.
- Latency and throughput
  - Capture into EMPTY gives o_dat_vld=1, first element (0,0), on the next cycle.
  - With i_dat_rdy held high, one element per cycle and SIZE*SIZE cycles per matrix, with no bubble between matrices.
- Overflow
  - i_matrix_vld & !acc drops the matrix; buffers and pointers are untouched.
  - o_ovf is set on the next cycle.
  - o_ovf holds until i_ovf_clr; if set and clear occur in the same cycle, set wins.
- Arithmetic
  - Index counters are IDX_W-bit and wrap naturally at SIZE.
  - No arithmetic is applied to data; elements pass through bit-exact.

Decomposition:
- Package sa_pkg holds:
  - SIZE, I_WIDTH, O_WIDTH, IDX_W localparams;
  - typedef res_t (logic [O_WIDTH-1:0]);
  - typedef res_mat_t (res_t [SIZE][SIZE]).
- Sub-module sa_mat_buf: one SIZE x SIZE register bank with a write-enable and a combinational row/col read mux, instantiated twice.
- Pointer and cursor control stays in sa_drain.

Test Plan:
- Single matrix, element (r,c)=16*r+c, rdy=1:
  - o_dat_vld rises 1 cycle after the pulse;
  - 16 consecutive elements 0,1,2,3,16,... through 51;
  - o_last only on value 51;
  - then o_dat_vld=0.
- Backpressure, same matrix, rdy toggling 1,0,0,1...:
  - o_dat, o_row and o_col are held while rdy=0;
  - all 16 values are delivered in order, none duplicated.
- Two pulses 3 cycles apart, rdy=1:
  - 32 elements back-to-back with no gap at the boundary;
  - o_last at elements 16 and 32.
- Three pulses with rdy=0:
  - third pulse is dropped and o_ovf=1 next cycle;
  - after rdy=1, exactly 32 elements (first two matrices) come out;
  - i_ovf_clr clears o_ovf.
- FULL, third pulse coincides with hs&o_last of the first matrix:
  - accepted, no o_ovf;
  - output order is matrix1, matrix2, matrix3.
- rst=1 asserted mid-matrix at element 7:
  - o_dat_vld=0 next cycle;
  - a new pulse afterwards streams from element (0,0).
